// File: rtl/uart_tx_drain.sv
// UART transmitter: pops one byte at a time from the tx fifo and shifts it out
// as start bit, LSB-first data, optional parity and stop bit(s).
module uart_tx_drain #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par;

  // Pop must land in IDLE so the byte can be captured in the very next cycle.
  assign fifo_pop = resetn && (state == S_IDLE) && enable && !fifo_empty;
  assign busy     = (state != S_IDLE) || fifo_pop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      div        <= '0;
      cnt        <= '0;
      shift      <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx  <= 1'b1;
          div <= '0;
          cnt <= '0;
          if (fifo_pop) state <= S_FETCH;
        end
        // The fifo only presents data in this cycle; latch it now.
        S_FETCH: begin
          shift <= fifo_data;
          par   <= (^fifo_data) ^ ODD;
          tx    <= 1'b0;
          div   <= '0;
          state <= S_START;
        end
        default: begin
          // Raised one cycle early so the registered pulse lines up with the last stop cycle.
          if (state == S_STOP && cnt == STOP_LAST && div == DIV_PRE) frame_done <= 1'b1;
          if (div != DIV_LAST) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            case (state)
              S_START: begin
                tx    <= shift[0];
                shift <= shift >> 1;
                cnt   <= '0;
                state <= S_DATA;
              end
              S_DATA: begin
                if (cnt == DATA_LAST) begin
                  cnt <= '0;
                  if (PARITY != 0) begin
                    tx    <= par;
                    state <= S_PARITY;
                  end else begin
                    tx    <= 1'b1;
                    state <= S_STOP;
                  end
                end else begin
                  tx    <= shift[0];
                  shift <= shift >> 1;
                  cnt   <= cnt + 1'b1;
                end
              end
              S_PARITY: begin
                tx    <= 1'b1;
                cnt   <= '0;
                state <= S_STOP;
              end
              S_STOP: begin
                if (cnt == STOP_LAST) begin
                  cnt   <= '0;
                  state <= S_IDLE;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: three instances (no parity / even parity /
// odd parity with two stop bits), each fed from its own read pointer into one shared byte list.
module tb_uart_tx_drain;

  localparam int unsigned CPB = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] empty;
  logic [2:0] pop;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;
  logic [7:0] fd0, fd1, fd2;

  logic [7:0] mem [32];
  int         wr = 0;
  int         rd [3] = '{0, 0, 0};
  logic [7:0] dq [3];
  logic [2:0] popd = 3'b000;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Fifo model: data is presented only in the cycle after a pop, zero otherwise.
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      popd[k] <= pop[k];
      if (pop[k]) begin
        dq[k] <= mem[rd[k]];
        rd[k] <= rd[k] + 1;
      end
    end
  end

  assign empty = {rd[2] == wr, rd[1] == wr, rd[0] == wr};
  assign fd0 = popd[0] ? dq[0] : 8'h00;
  assign fd1 = popd[1] ? dq[1] : 8'h00;
  assign fd2 = popd[2] ? dq[2] : 8'h00;

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_none (
    .clock(clock), .resetn(resetn), .enable(enable), .fifo_empty(empty[0]), .fifo_data(fd0),
    .fifo_pop(pop[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_even (
    .clock(clock), .resetn(resetn), .enable(enable), .fifo_empty(empty[1]), .fifo_data(fd1),
    .fifo_pop(pop[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_odd (
    .clock(clock), .resetn(resetn), .enable(enable), .fifo_empty(empty[2]), .fifo_data(fd2),
    .fifo_pop(pop[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr++;
    #1;
  endtask

  task automatic wait_pop(input int g, output int waited);
    waited = 0;
    #1;
    while (!pop[g] && waited < 200) begin
      @(negedge clock);
      waited++;
    end
  endtask

  // Follows one frame of instance g from its pop cycle to its frame_done cycle.
  task automatic run_frame(input int g, input logic [7:0] b, input int par, input int stops,
                           input string tag, output int waited);
    int   len;
    int   idx;
    int   tx_err;
    int   done_err;
    int   busy_err;
    logic p;
    logic e;
    len = (1 + 8 + ((par != 0) ? 1 : 0) + stops) * CPB;
    tx_err = 0;
    done_err = 0;
    busy_err = 0;
    p = (^b) ^ (par == 2);
    wait_pop(g, waited);
    check({tag, " pop"}, 32'(pop[g]), 32'd1);
    if (!pop[g]) return;
    check({tag, " pop cycle busy/tx"}, {30'd0, busy[g], tx[g]}, 32'h3);
    @(negedge clock);
    check({tag, " fetch pop/tx/busy"}, {29'd0, pop[g], tx[g], busy[g]}, 32'h3);
    for (int n = 0; n < len; n++) begin
      @(negedge clock);
      idx = n / CPB;
      if (idx == 0) e = 1'b0;
      else if (idx <= 8) e = b[idx-1];
      else if (par != 0 && idx == 9) e = p;
      else e = 1'b1;
      if (tx[g] !== e) tx_err++;
      if (done[g] !== (n == len - 1)) done_err++;
      if (busy[g] !== 1'b1) busy_err++;
    end
    check({tag, " tx bit errors"}, 32'(tx_err), 32'd0);
    check({tag, " frame_done errors"}, 32'(done_err), 32'd0);
    check({tag, " busy errors"}, 32'(busy_err), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while ((busy != 3'b000 || empty != 3'b111) && c < 500);
    check({tag, " idle"}, {29'd0, busy}, 32'd0);
  endtask

  initial begin
    int w;
    int bad;

    // Reset state
    repeat (2) @(negedge clock);
    check("reset tx", {29'd0, tx}, 32'h7);
    check("reset busy", {29'd0, busy}, 32'h0);
    check("reset pop", {29'd0, pop}, 32'h0);
    check("reset frame_done", {29'd0, done}, 32'h0);
    resetn = 1'b1;
    @(negedge clock);

    // Single byte, plain frame
    push(8'hA5);
    run_frame(0, 8'hA5, 0, 1, "a5", w);
    @(negedge clock);
    check("a5 after frame tx/busy/pop", {29'd0, tx[0], busy[0], pop[0]}, 32'h4);
    wait_idle("a5");

    // Back-to-back bytes
    push(8'h01);
    push(8'h80);
    run_frame(0, 8'h01, 0, 1, "b2b first", w);
    run_frame(0, 8'h80, 0, 1, "b2b second", w);
    check("b2b cycles from frame_done to pop", 32'(w), 32'd1);
    wait_idle("b2b");

    // Parity and two stop bits
    push(8'h07);
    fork
      run_frame(1, 8'h07, 1, 1, "even 07", w);
      begin
        int w2;
        run_frame(2, 8'h07, 2, 2, "odd 07 2stop", w2);
      end
    join
    wait_idle("parity");

    // enable low with pending data
    enable = 1'b0;
    push(8'h3C);
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (pop !== 3'b000 || tx !== 3'b111) bad++;
    end
    check("disabled no pop", 32'(bad), 32'd0);

    // enable dropped mid-frame
    enable = 1'b1;
    fork
      run_frame(0, 8'h3C, 0, 1, "mid-disable", w);
      begin
        repeat (10) @(negedge clock);
        enable = 1'b0;
        push(8'h55);
      end
    join
    bad = 0;
    repeat (70) begin
      @(negedge clock);
      if (pop !== 3'b000 || tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("stays idle after disable", 32'(bad), 32'd0);
    enable = 1'b1;
    wait_idle("drain 55");

    // Reset during data bit 3 (bit 3 of F7 is 0, so tx is low there)
    push(8'hF7);
    wait_pop(0, w);
    check("rst pop", 32'(pop[0]), 32'd1);
    repeat (19) @(negedge clock);
    check("rst pre tx/busy", {30'd0, tx[0], busy[0]}, 32'h1);
    #1 resetn = 1'b0;
    #1;
    check("rst abort tx", {29'd0, tx}, 32'h7);
    check("rst abort busy/done", {26'd0, busy, done}, 32'h0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    push(8'h81);
    run_frame(0, 8'h81, 0, 1, "post-reset", w);
    wait_idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
